// File: rtl/dac_stream_ctrl.sv
// dac_stream_ctrl: paced sample FIFO between the core and the DAC.
// Buffers samples, primes to half-full, then issues one per divider tick.
module dac_stream_ctrl #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4,
    parameter int DIV_W = 16
) (
    input  logic                     CLK,
    input  logic                     reset_n,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     enable,
    input  logic [DIV_W-1:0]         div,
    input  logic                     mute,
    input  logic                     clr_underflow,
    output logic [WIDTH-1:0]         dac_d,
    output logic                     dac_update,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     underflow,
    output logic [1:0]               state
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [WIDTH-1:0] MID = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic [LW-1:0] HALF = LW'(DEPTH / 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t st, st_nx;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [LW-1:0]    level;
    logic [DIV_W-1:0] cnt;

    logic push, pop, tick, run_en, empty_tick;

    assign state      = st;
    assign fifo_level = level;
    assign in_ready   = (level != FULL);
    assign push       = in_valid && in_ready;

    // State register
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) st <= IDLE;
        else          st <= st_nx;
    end

    // Next-state logic; dropping enable always wins
    always_comb begin
        st_nx = st;
        if (!enable) begin
            st_nx = IDLE;
        end else begin
            unique case (st)
                IDLE:    st_nx = PRIME;
                PRIME:   if (level >= HALF) st_nx = RUN;
                RUN:     st_nx = RUN;
                default: st_nx = IDLE;
            endcase
        end
    end

    // Output decode: pacing tick and FIFO pop, gated so a dropped enable issues nothing
    always_comb begin
        run_en     = (st == RUN) && enable;
        tick       = run_en && (cnt >= div);
        pop        = tick && (level != '0);
        empty_tick = tick && (level == '0);
    end

    // Sample-period divider, held at zero outside RUN
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n)    cnt <= '0;
        else if (!run_en) cnt <= '0;
        else if (tick)    cnt <= '0;
        else              cnt <= cnt + DIV_W'(1);
    end

    // FIFO storage; contents are don't-care once pointers reset
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      level <= level + LW'(1);
            else if (pop && !push) level <= level - LW'(1);
        end
    end

    // DAC code register and update strobe; mute still consumes the sample
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            dac_d      <= MID;
            dac_update <= 1'b0;
        end else begin
            dac_update <= pop;
            if (pop) dac_d <= mute ? MID : mem[rd_ptr];
        end
    end

    // Sticky underflow; a new empty tick beats a simultaneous clear
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n)          underflow <= 1'b0;
        else if (empty_tick)   underflow <= 1'b1;
        else if (clr_underflow) underflow <= 1'b0;
    end

endmodule

// File: tb/tb_dac_stream_ctrl.sv
// tb_dac_stream_ctrl: directed table plus hand sequences for dac_stream_ctrl.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_dac_stream_ctrl;

    logic        CLK = 1'b0;
    logic        reset_n;
    logic [9:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        enable;
    logic [15:0] div;
    logic        mute;
    logic        clr_underflow;
    logic [9:0]  dac_d;
    logic        dac_update;
    logic [2:0]  fifo_level;
    logic        underflow;
    logic [1:0]  state;

    int checks = 0;
    int failures = 0;

    dac_stream_ctrl #(.WIDTH(10), .DEPTH(4), .DIV_W(16)) dut (
        .CLK(CLK),
        .reset_n(reset_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .enable(enable),
        .div(div),
        .mute(mute),
        .clr_underflow(clr_underflow),
        .dac_d(dac_d),
        .dac_update(dac_update),
        .fifo_level(fifo_level),
        .underflow(underflow),
        .state(state)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        v;
        logic [9:0]  d;
        logic        en;
        logic [15:0] dv;
        logic        mu;
        logic        clr;
        logic [9:0]  e_dac;
        logic        e_upd;
        logic [2:0]  e_lvl;
        logic        e_uf;
        logic [1:0]  e_st;
        logic        e_rdy;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input int idx,
                       input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all(input int idx, input vec_t x);
        chk("dac_d", idx, dac_d, x.e_dac);
        chk("dac_update", idx, dac_update, x.e_upd);
        chk("fifo_level", idx, fifo_level, x.e_lvl);
        chk("underflow", idx, underflow, x.e_uf);
        chk("state", idx, state, x.e_st);
        chk("in_ready", idx, in_ready, x.e_rdy);
    endtask

    function automatic vec_t mk(logic v, logic [9:0] d, logic en,
                                logic [15:0] dv, logic mu, logic clr,
                                logic [9:0] ed, logic eu, logic [2:0] el,
                                logic ef, logic [1:0] es, logic er);
        vec_t r;
        r.v = v; r.d = d; r.en = en; r.dv = dv; r.mu = mu; r.clr = clr;
        r.e_dac = ed; r.e_upd = eu; r.e_lvl = el;
        r.e_uf = ef; r.e_st = es; r.e_rdy = er;
        return r;
    endfunction

    logic [9:0] got[$];
    vec_t rv;

    initial begin
        // prime + pacing, div = 3
        vq.push_back(mk(1, 10'h100, 1, 3, 0, 0, 10'h200, 0, 1, 0, 1, 1));
        vq.push_back(mk(1, 10'h200, 1, 3, 0, 0, 10'h200, 0, 2, 0, 1, 1));
        vq.push_back(mk(1, 10'h300, 1, 3, 0, 0, 10'h200, 0, 3, 0, 2, 1));
        vq.push_back(mk(1, 10'h3FF, 1, 3, 0, 0, 10'h200, 0, 4, 0, 2, 0));
        vq.push_back(mk(0, 0, 1, 3, 0, 0, 10'h200, 0, 4, 0, 2, 0));
        vq.push_back(mk(0, 0, 1, 3, 0, 0, 10'h200, 0, 4, 0, 2, 0));
        vq.push_back(mk(0, 0, 1, 3, 0, 0, 10'h100, 1, 3, 0, 2, 1));
        vq.push_back(mk(0, 0, 1, 3, 0, 0, 10'h100, 0, 3, 0, 2, 1));
        vq.push_back(mk(0, 0, 1, 3, 0, 0, 10'h100, 0, 3, 0, 2, 1));
        vq.push_back(mk(0, 0, 1, 3, 0, 0, 10'h100, 0, 3, 0, 2, 1));
        vq.push_back(mk(0, 0, 1, 3, 0, 0, 10'h200, 1, 2, 0, 2, 1));
        vq.push_back(mk(0, 0, 1, 3, 0, 0, 10'h200, 0, 2, 0, 2, 1));
        vq.push_back(mk(0, 0, 1, 3, 0, 0, 10'h200, 0, 2, 0, 2, 1));
        vq.push_back(mk(0, 0, 1, 3, 0, 0, 10'h200, 0, 2, 0, 2, 1));
        vq.push_back(mk(0, 0, 1, 3, 0, 0, 10'h300, 1, 1, 0, 2, 1));
        vq.push_back(mk(0, 0, 1, 3, 0, 0, 10'h300, 0, 1, 0, 2, 1));
        vq.push_back(mk(0, 0, 1, 3, 0, 0, 10'h300, 0, 1, 0, 2, 1));
        vq.push_back(mk(0, 0, 1, 3, 0, 0, 10'h300, 0, 1, 0, 2, 1));
        vq.push_back(mk(0, 0, 1, 3, 0, 0, 10'h3FF, 1, 0, 0, 2, 1));
        // underflow, clear without tick, clear vs. empty tick
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 10'h3FF, 0, 0, 1, 2, 1));
        vq.push_back(mk(0, 0, 1, 5, 0, 1, 10'h3FF, 0, 0, 0, 2, 1));
        vq.push_back(mk(0, 0, 1, 0, 0, 1, 10'h3FF, 0, 0, 1, 2, 1));
        // mute; push on an empty tick is stored
        vq.push_back(mk(1, 10'h0AA, 1, 0, 1, 0, 10'h3FF, 0, 1, 1, 2, 1));
        vq.push_back(mk(1, 10'h155, 1, 0, 1, 0, 10'h200, 1, 1, 1, 2, 1));
        vq.push_back(mk(0, 0, 1, 0, 1, 0, 10'h200, 1, 0, 1, 2, 1));
        // enable drop with 2 queued, then re-enable
        vq.push_back(mk(1, 10'h011, 1, 15, 0, 0, 10'h200, 0, 1, 1, 2, 1));
        vq.push_back(mk(1, 10'h022, 1, 15, 0, 0, 10'h200, 0, 2, 1, 2, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 10'h200, 0, 2, 1, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 10'h200, 0, 2, 1, 0, 1));
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 10'h200, 0, 2, 1, 1, 1));
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 10'h200, 0, 2, 1, 2, 1));
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 10'h011, 1, 1, 1, 2, 1));
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 10'h022, 1, 0, 1, 2, 1));
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 10'h022, 0, 0, 1, 2, 1));

        // reset with arbitrary inputs
        reset_n = 1'b0;
        in_valid = 1'b1; in_data = 10'h3FF; enable = 1'b1;
        div = 16'd0; mute = 1'b1; clr_underflow = 1'b0;
        step();
        step();
        rv = mk(0, 0, 0, 0, 0, 0, 10'h200, 0, 0, 0, 0, 1);
        chk_all(-1, rv);

        in_valid = 1'b0; in_data = '0; enable = 1'b0; mute = 1'b0;
        reset_n = 1'b1;
        step();

        for (int i = 0; i < vq.size(); i++) begin
            in_valid = vq[i].v;
            in_data = vq[i].d;
            enable = vq[i].en;
            div = vq[i].dv;
            mute = vq[i].mu;
            clr_underflow = vq[i].clr;
            step();
            chk_all(i, vq[i]);
        end

        // backpressure: enable low, offer 1..6
        in_valid = 1'b0; enable = 1'b0; clr_underflow = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1;
            in_data = 10'(i);
            chk("bp_in_ready", i, in_ready, (i <= 4) ? 1 : 0);
            step();
            chk("bp_level", i, fifo_level, (i <= 4) ? i : 4);
        end
        in_valid = 1'b0;
        enable = 1'b1;
        div = 16'd0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (dac_update) got.push_back(dac_d);
        end
        chk("bp_count", 0, got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) chk("bp_order", i, got[i], i + 1);
            else chk("bp_order", i, -1, i + 1);
        end
        chk("bp_uf", 0, underflow, 1);

        // asynchronous reset mid-stream
        enable = 1'b0;
        in_valid = 1'b1;
        in_data = 10'h0F0;
        step();
        step();
        in_valid = 1'b0;
        chk("pre_rst_level", 0, fifo_level, 2);
        #2;
        reset_n = 1'b0;
        #1;
        rv = mk(0, 0, 0, 0, 0, 0, 10'h200, 0, 0, 0, 0, 1);
        chk_all(-2, rv);
        step();
        reset_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dac_stream_ctrl.md
Name: dac_stream_ctrl

Overview:
- Sequences the 10-bit core-to-DAC sample path: buffers samples produced by the rvmyth core and issues them to avsddac at a programmable sample rate.
- Sits between core.OUT and dac.D in vsdbabysoc, clocked by the PLL CLK.
- Provides rate pacing, FIFO priming, mute-to-midscale, and sticky underflow reporting.

Parameters:
- WIDTH, 10, sample width (DAC D width).
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- DIV_W, 16, width of the sample-period divider.

Ports:
- CLK  input  1  clock from the PLL.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  sample from the core.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  FIFO can accept; a push occurs when in_valid and in_ready are both high.
- enable  input  1  run sample pacing.
- div  input  DIV_W  sample period minus 1, in CLK cycles.
- mute  input  1  force the DAC code to midscale.
- clr_underflow  input  1  clear the sticky underflow flag.
- dac_d  output  WIDTH  registered code to avsddac D.
- dac_update  output  1  one-cycle strobe, high in the cycle a new dac_d value appears.
- fifo_level  output  log2(DEPTH)+1  current FIFO occupancy.
- underflow  output  1  sticky; a tick found the FIFO empty.
- state  output  2  0 = IDLE, 1 = PRIME, 2 = RUN.

Behaviour:
- Reset (async assert, sync release), all outputs:
  - dac_d = MID = 2^(WIDTH-1) (512).
  - dac_update = 0, underflow = 0, fifo_level = 0, state = IDLE.
  - Divider counter = 0, FIFO empty, so in_ready = 1.
- FIFO:
  - in_ready = (level != DEPTH), combinational from registered level.
  - Push is accepted in every state, including IDLE.
  - A push and a pop in the same cycle leave level unchanged.
  - Read and write pointers wrap modulo DEPTH.
- FSM:
  - IDLE -> PRIME when enable = 1.
  - PRIME -> RUN when level >= DEPTH/2, checked on the registered level.
  - Any state -> IDLE when enable = 0 (takes priority). On entering IDLE, the counter clears; the FIFO contents and dac_d are held.
  - RUN stays in RUN while enable = 1, even after an underflow.
- Divider (RUN only):
  - The counter increments each cycle.
  - When counter >= div: tick, and the counter returns to 0.
  - div = 0 gives a tick every cycle.
  - If div is lowered below the current counter value, a tick occurs the next cycle.
  - The first tick occurs div+1 cycles after entering RUN.
  - The counter is held at 0 outside RUN.
- On a tick with level > 0:
  - Pop the head entry.
  - Next cycle: dac_d = mute ? MID : head, and dac_update = 1.
  - The pop occurs regardless of mute.
- On a tick with level == 0 (a push in the same cycle does not count):
  - dac_d is held and dac_update = 0.
  - underflow is set next cycle.
  - The pushed sample is stored normally.
- Mute with no tick: dac_d changes only at ticks, so mute takes effect at the next tick.
- underflow: set on an empty tick; cleared by clr_underflow. If set and clear coincide, set wins.
- Latency: a sample pushed into an empty FIFO in RUN reaches dac_d on the first tick after it is stored, plus 1 cycle.
- Reset mid-stream: immediate return to reset values; FIFO contents are discarded.

Test Plan:
- Reset check: assert reset_n = 0 with arbitrary inputs.
  - -> dac_d = 512, dac_update = 0, underflow = 0, in_ready = 1, state = 0.
- Prime and pacing: enable = 1, div = 3; push 0x100, 0x200, 0x300, 0x3FF back-to-back.
  - -> state goes PRIME -> RUN after level reaches 2.
  - -> dac_update pulses exactly every 4 cycles, with dac_d = 0x100, 0x200, 0x300, 0x3FF in order.
- Backpressure: enable = 0; hold in_valid = 1 for 6 cycles with data 1..6.
  - -> in_ready drops after 4 pushes; level = 4; data 5 is not accepted until a pop.
- Underflow: div = 0, RUN, FIFO drained.
  - -> next tick: dac_d holds its last value, no dac_update, underflow = 1.
  - -> clr_underflow with no tick clears it.
  - -> clr_underflow coinciding with an empty tick leaves underflow = 1.
- Mute: stream 0x0AA, 0x155 with mute = 1.
  - -> dac_d = 512 at both ticks; level still decrements by 2.
- Enable drop mid-stream: drop enable with 2 entries queued.
  - -> state = IDLE, no further dac_update, dac_d and level held.
  - -> re-enable: PRIME -> RUN immediately (level 2 >= 2); next output is the queued head.
